bus_master_if: RTL and testbench
================================

BUS_MASTER_IF -- requirements
Module: bus_master_if

Interface
REQ-001 Parameter ADDR_W, default 30, SHALL set the word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  reset is synchronous and active-low: sampled only at the clk rising edge, asserted when 0.
REQ-005 as_  in  1  CPU access strobe, active-low.
REQ-006 rw  in  1  CPU access direction: 1 = read, 0 = write.
REQ-007 addr  in  ADDR_W  CPU word address.
REQ-008 wr_data  in  DATA_W  CPU write data.
REQ-009 stall  in  1  pipeline stall, active-high.
REQ-010 flush  in  1  pipeline flush, active-high.
REQ-011 busy  out  1  access in progress; CPU SHALL hold its pipeline while 1.
REQ-012 rd_data  out  DATA_W  read result to CPU.
REQ-013 bus_req_  out  1  bus request to the arbiter, active-low.
REQ-014 bus_grnt_  in  1  bus grant from the arbiter, active-low.
REQ-015 bus_as_  out  1  bus address strobe, active-low.
REQ-016 bus_rw  out  1  bus direction: 1 = read, 0 = write.
REQ-017 bus_addr  out  ADDR_W  bus word address.
REQ-018 bus_wr_data  out  DATA_W  bus write data.
REQ-019 bus_rdy_  in  1  slave ready, active-low.
REQ-020 bus_rd_data  in  DATA_W  slave read data, valid when bus_rdy_ = 0.

Function
REQ-021 FSM states: IDLE, REQ, ACCESS, WAIT; bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data, rd_buf SHALL be registers.
REQ-022 IDLE: if as_ = 0 and flush = 0 -> latch addr/rw/wr_data into bus_addr/bus_rw/bus_wr_data, drive bus_req_ = 0, go to REQ; else stay.
REQ-023 IDLE: busy SHALL be 1 combinationally in the cycle the access is accepted (as_ = 0, flush = 0), else 0.
REQ-024 REQ: bus_req_ held 0; on bus_grnt_ = 0 -> drive bus_as_ = 0 for exactly one cycle, go to ACCESS; busy = 1.
REQ-025 ACCESS: bus_as_ = 1; bus_req_ held 0 until bus_rdy_ = 0; busy = 1 while bus_rdy_ = 1.
REQ-026 ACCESS with bus_rdy_ = 0: busy = 0 and rd_data = bus_rd_data that cycle; on that edge, bus_req_ -> 1, rd_buf <= bus_rd_data when bus_rw = 1, next state WAIT if stall = 1 else IDLE.
REQ-027 WAIT: busy = 0, rd_data = rd_buf; return to IDLE on first cycle with stall = 0; no new access accepted while in WAIT.
REQ-028 In all states other than the ACCESS-ready cycle, rd_data SHALL equal rd_buf.
REQ-029 flush SHALL only suppress acceptance in IDLE; a transaction in REQ/ACCESS SHALL complete to the slave.
REQ-030 Minimum latency with immediate grant and ready: as_ accept cycle N, bus_as_ = 0 in cycle N+2, data returned in cycle N+3.
REQ-031 bus_addr/bus_rw/bus_wr_data SHALL remain stable from latch until the exit from ACCESS.
REQ-032 Write completion: rd_buf SHALL be unchanged.
REQ-033 bus_grnt_ toggling while in IDLE or WAIT SHALL have no effect.

Reset
REQ-034 On reset = 0 at a clk edge: state = IDLE, bus_req_ = 1, bus_as_ = 1, bus_rw = 1, bus_addr = 0, bus_wr_data = 0, rd_buf = 0; busy = 0, rd_data = 0.
REQ-035 Reset during REQ or ACCESS SHALL abandon the transaction; bus_req_ = 1 and bus_as_ = 1 from the next cycle.

Verification
REQ-036 Read, grant and ready immediate, addr = 0x0000100, bus_rd_data = 0xDEADBEEF -> bus_as_ low one cycle at N+2, rd_data = 0xDEADBEEF with busy = 0 at N+3, bus_req_ = 1 at N+4.
REQ-037 Write wr_data = 0x12345678, grant withheld 5 cycles -> bus_req_ = 0 throughout, bus_as_ asserted only after grant, bus_wr_data = 0x12345678, rd_buf unchanged.
REQ-038 Read with bus_rdy_ delayed 3 cycles and stall = 1 for 4 cycles after ready -> FSM in WAIT, rd_data holds returned value, IDLE after stall drops.
REQ-039 as_ = 0 with flush = 1 in IDLE -> no bus_req_, busy = 0; flush = 1 during ACCESS -> transaction still completes.
REQ-040 reset = 0 asserted in ACCESS -> next cycle bus_req_ = 1, bus_as_ = 1, busy = 0, rd_data = 0, state IDLE.

Source files
------------

// File: rtl/bus_master_if_if.sv
// Arbitrated system-bus signals between one bus master and the slave/arbiter side.
// Active-low signals keep their trailing underscore.
interface bus_master_if_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic              bus_rdy_;
  logic [DATA_W-1:0] bus_rd_data;

  modport master (
    output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    input  bus_grnt_, bus_rdy_, bus_rd_data
  );

  modport slave (
    input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    output bus_grnt_, bus_rdy_, bus_rd_data
  );
endinterface

// File: rtl/bus_master_if.sv
// CPU-side bus master: takes one CPU access, requests the bus, strobes the address
// for one cycle, waits for slave ready, and holds read data across pipeline stalls.
module bus_master_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              stall,
  input  logic              flush,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  bus_master_if_if.master   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACCESS = 2'd2, WAIT = 2'd3} state_t;

  state_t            state, state_nxt;
  logic              req_q, req_d;
  logic              as_q, as_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] rd_buf, rd_buf_d;

  assign bus.bus_req_    = req_q;
  assign bus.bus_as_     = as_q;
  assign bus.bus_rw      = rw_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_wr_data = wd_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      req_q  <= 1'b1;
      as_q   <= 1'b1;
      rw_q   <= 1'b1;
      addr_q <= '0;
      wd_q   <= '0;
      rd_buf <= '0;
    end else begin
      state  <= state_nxt;
      req_q  <= req_d;
      as_q   <= as_d;
      rw_q   <= rw_d;
      addr_q <= addr_d;
      wd_q   <= wd_d;
      rd_buf <= rd_buf_d;
    end
  end

  always_comb begin
    state_nxt = state;
    req_d     = req_q;
    as_d      = 1'b1;   // address strobe is a single-cycle pulse
    rw_d      = rw_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    rd_buf_d  = rd_buf;
    busy      = 1'b0;
    rd_data   = rd_buf;
    case (state)
      IDLE: begin
        if (!as_ && !flush) begin
          busy      = 1'b1;
          rw_d      = rw;
          addr_d    = addr;
          wd_d      = wr_data;
          req_d     = 1'b0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        busy  = 1'b1;
        req_d = 1'b0;
        if (!bus.bus_grnt_) begin
          as_d      = 1'b0;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        busy = bus.bus_rdy_;
        // Ready cycle: forward slave data straight through so the CPU can move on.
        if (!bus.bus_rdy_) begin
          rd_data   = bus.bus_rd_data;
          req_d     = 1'b1;
          if (rw_q) rd_buf_d = bus.bus_rd_data;
          state_nxt = stall ? WAIT : IDLE;
        end
      end
      WAIT: begin
        if (!stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: inputs change 1 time unit after clk rises,
// outputs are checked on the falling edge.
module tb_bus_master_if;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              as_, rw, stall, flush;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic [DATA_W-1:0] rd_data;
  int total = 0;
  int bad = 0;

  bus_master_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .as_(as_), .rw(rw), .addr(addr), .wr_data(wr_data),
    .stall(stall), .flush(flush), .busy(busy), .rd_data(rd_data), .bus(bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    @(negedge clk);
    total++; if (bif.bus_req_ !== 1'b1) begin bad++; $display("FAIL rst_req got=%b exp=1", bif.bus_req_); end
    total++; if (bif.bus_as_ !== 1'b1) begin bad++; $display("FAIL rst_as got=%b exp=1", bif.bus_as_); end
    total++; if (bif.bus_rw !== 1'b1) begin bad++; $display("FAIL rst_rw got=%b exp=1", bif.bus_rw); end
    total++; if (bif.bus_addr !== 30'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bif.bus_addr); end
    total++; if (bif.bus_wr_data !== 32'h0) begin bad++; $display("FAIL rst_wd got=%h exp=0", bif.bus_wr_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_rd got=%h exp=0", rd_data); end
    total++; if (dut.state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dut.state); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_grant_idle();
    bif.bus_grnt_ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      total++; if (bif.bus_req_ !== 1'b1 || bif.bus_as_ !== 1'b1 || dut.state !== 2'd0)
        begin bad++; $display("FAIL grnt_idle req=%b as=%b st=%0d exp 1 1 0", bif.bus_req_, bif.bus_as_, dut.state); end
    end
    bif.bus_grnt_ = 1'b1;
    tick();
  endtask

  task automatic test_read_fast();
    // cycle N: accept
    as_ = 1'b0; rw = 1'b1; addr = 30'h0000100; bif.bus_grnt_ = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rf_accept_busy got=%b exp=1", busy); end
    total++; if (bif.bus_req_ !== 1'b1) begin bad++; $display("FAIL rf_accept_req got=%b exp=1", bif.bus_req_); end
    tick(); as_ = 1'b1; addr = 30'h3FFFFFFF;
    // N+1: REQ
    @(negedge clk);
    total++; if (bif.bus_req_ !== 1'b0 || bif.bus_as_ !== 1'b1 || busy !== 1'b1)
      begin bad++; $display("FAIL rf_n1 req=%b as=%b busy=%b exp 0 1 1", bif.bus_req_, bif.bus_as_, busy); end
    total++; if (bif.bus_addr !== 30'h0000100) begin bad++; $display("FAIL rf_addr got=%h exp=0000100", bif.bus_addr); end
    tick();
    // N+2: strobe
    @(negedge clk);
    total++; if (bif.bus_as_ !== 1'b0 || busy !== 1'b1 || bif.bus_rw !== 1'b1)
      begin bad++; $display("FAIL rf_n2 as=%b busy=%b rw=%b exp 0 1 1", bif.bus_as_, busy, bif.bus_rw); end
    tick(); bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'hDEADBEEF;
    // N+3: data
    @(negedge clk);
    total++; if (bif.bus_as_ !== 1'b1) begin bad++; $display("FAIL rf_n3_as got=%b exp=1", bif.bus_as_); end
    total++; if (busy !== 1'b0 || rd_data !== 32'hDEADBEEF)
      begin bad++; $display("FAIL rf_n3 busy=%b rd=%h exp 0 deadbeef", busy, rd_data); end
    total++; if (bif.bus_req_ !== 1'b0) begin bad++; $display("FAIL rf_n3_req got=%b exp=0", bif.bus_req_); end
    tick(); bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1; bif.bus_rd_data = 32'h0;
    // N+4: released, data held
    @(negedge clk);
    total++; if (bif.bus_req_ !== 1'b1 || rd_data !== 32'hDEADBEEF || dut.state !== 2'd0)
      begin bad++; $display("FAIL rf_n4 req=%b rd=%h st=%0d exp 1 deadbeef 0", bif.bus_req_, rd_data, dut.state); end
    tick();
  endtask

  task automatic test_write_grant_delay();
    as_ = 1'b0; rw = 1'b0; addr = 30'h55; wr_data = 32'h12345678;
    tick(); as_ = 1'b1; wr_data = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bif.bus_req_ !== 1'b0 || bif.bus_as_ !== 1'b1 || busy !== 1'b1)
        begin bad++; $display("FAIL wr_wait%0d req=%b as=%b busy=%b exp 0 1 1", i, bif.bus_req_, bif.bus_as_, busy); end
      tick();
    end
    bif.bus_grnt_ = 1'b0;
    tick(); bif.bus_grnt_ = 1'b1;
    @(negedge clk);
    total++; if (bif.bus_as_ !== 1'b0 || bif.bus_rw !== 1'b0 || bif.bus_wr_data !== 32'h12345678)
      begin bad++; $display("FAIL wr_strobe as=%b rw=%b wd=%h exp 0 0 12345678", bif.bus_as_, bif.bus_rw, bif.bus_wr_data); end
    tick(); bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'hBAD0BAD0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || bif.bus_wr_data !== 32'h12345678)
      begin bad++; $display("FAIL wr_rdy busy=%b wd=%h exp 0 12345678", busy, bif.bus_wr_data); end
    tick(); bif.bus_rdy_ = 1'b1;
    @(negedge clk);
    total++; if (rd_data !== 32'hDEADBEEF || dut.state !== 2'd0 || bif.bus_req_ !== 1'b1)
      begin bad++; $display("FAIL wr_done rd=%h st=%0d req=%b exp deadbeef 0 1", rd_data, dut.state, bif.bus_req_); end
    tick();
  endtask

  task automatic test_read_stall();
    as_ = 1'b0; rw = 1'b1; addr = 30'h200; bif.bus_grnt_ = 1'b0;
    tick(); as_ = 1'b1;
    tick(); bif.bus_grnt_ = 1'b1;
    // first ACCESS cycle plus two more with ready withheld
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b1 || dut.state !== 2'd2)
        begin bad++; $display("FAIL rs_hold%0d busy=%b st=%0d exp 1 2", i, busy, dut.state); end
      tick();
    end
    bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'hCAFEF00D; stall = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || rd_data !== 32'hCAFEF00D)
      begin bad++; $display("FAIL rs_rdy busy=%b rd=%h exp 0 cafef00d", busy, rd_data); end
    tick(); bif.bus_rdy_ = 1'b1; bif.bus_rd_data = 32'h0; as_ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bif.bus_grnt_ = i[0];
      @(negedge clk);
      total++; if (dut.state !== 2'd3 || rd_data !== 32'hCAFEF00D || busy !== 1'b0 || bif.bus_req_ !== 1'b1)
        begin bad++; $display("FAIL rs_wait%0d st=%0d rd=%h busy=%b req=%b exp 3 cafef00d 0 1", i, dut.state, rd_data, busy, bif.bus_req_); end
      tick();
    end
    as_ = 1'b1; stall = 1'b0; bif.bus_grnt_ = 1'b1;
    tick();
    @(negedge clk);
    total++; if (dut.state !== 2'd0 || rd_data !== 32'hCAFEF00D)
      begin bad++; $display("FAIL rs_idle st=%0d rd=%h exp 0 cafef00d", dut.state, rd_data); end
    tick();
  endtask

  task automatic test_flush();
    as_ = 1'b0; flush = 1'b1; rw = 1'b1; addr = 30'h300;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fl_idle_busy got=%b exp=0", busy); end
    tick();
    @(negedge clk);
    total++; if (bif.bus_req_ !== 1'b1 || dut.state !== 2'd0)
      begin bad++; $display("FAIL fl_idle req=%b st=%0d exp 1 0", bif.bus_req_, dut.state); end
    flush = 1'b0;
    tick(); as_ = 1'b1; flush = 1'b1; bif.bus_grnt_ = 1'b0;
    tick(); bif.bus_grnt_ = 1'b1;
    @(negedge clk);
    total++; if (bif.bus_as_ !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL fl_access as=%b busy=%b exp 0 1", bif.bus_as_, busy); end
    tick(); bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'h0F0F0F0F;
    @(negedge clk);
    total++; if (busy !== 1'b0 || rd_data !== 32'h0F0F0F0F)
      begin bad++; $display("FAIL fl_rdy busy=%b rd=%h exp 0 0f0f0f0f", busy, rd_data); end
    tick(); bif.bus_rdy_ = 1'b1; flush = 1'b0;
    @(negedge clk);
    total++; if (rd_data !== 32'h0F0F0F0F || dut.state !== 2'd0)
      begin bad++; $display("FAIL fl_done rd=%h st=%0d exp 0f0f0f0f 0", rd_data, dut.state); end
    tick();
  endtask

  task automatic test_reset_access();
    as_ = 1'b0; rw = 1'b1; addr = 30'h400; bif.bus_grnt_ = 1'b0;
    tick(); as_ = 1'b1;
    tick(); bif.bus_grnt_ = 1'b1;
    @(negedge clk);
    total++; if (dut.state !== 2'd2) begin bad++; $display("FAIL ra_in_access st=%0d exp=2", dut.state); end
    reset = 1'b0;
    tick();
    @(negedge clk);
    total++; if (bif.bus_req_ !== 1'b1 || bif.bus_as_ !== 1'b1 || busy !== 1'b0 || rd_data !== 32'h0 || dut.state !== 2'd0)
      begin bad++; $display("FAIL ra_after req=%b as=%b busy=%b rd=%h st=%0d exp 1 1 0 0 0", bif.bus_req_, bif.bus_as_, busy, rd_data, dut.state); end
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0; stall = 1'b0; flush = 1'b0;
    bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b1; bif.bus_rd_data = '0;
    #1;
    test_reset();
    test_grant_idle();
    test_read_fast();
    test_write_grant_delay();
    test_read_stall();
    test_flush();
    test_reset_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
